// File: rtl/vram_text_engine_pkg.sv
// Shared types and screen geometry for the text-mode VRAM and its fill engine.
package vram_text_engine_pkg;

  localparam int VRAM_COLS       = 40;
  localparam int VRAM_ROWS       = 30;
  localparam int VGA_SCREEN_SIZE = VRAM_COLS * VRAM_ROWS;

  typedef enum logic {VRAM_CLEAR, VRAM_SCROLL} vram_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_WR,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_SCR_FILL,
    ST_DONE
  } vram_state_t;

  // True while the engine owns (or is waiting for) the shared memory port.
  function automatic logic is_busy(vram_state_t s);
    return (s == ST_CLR_WR) || (s == ST_SCR_RD) || (s == ST_SCR_WR) || (s == ST_SCR_FILL);
  endfunction

endpackage

// File: rtl/vram_text_engine_if.sv
// CPU bus, VGA read port and command handshake of the text-mode VRAM.
interface vram_text_engine_if
  import vram_text_engine_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int VGA_W  = $clog2(VGA_SCREEN_SIZE)
);

  logic              we;
  logic              re;
  logic [ADDR_W-1:0] a;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       rd;
  logic [VGA_W-1:0]  vga_addr;
  logic [31:0]       vga_data;
  logic              cmd_valid;
  vram_op_t          cmd_op;
  logic [31:0]       cmd_fill;
  logic              cmd_ready;
  logic              busy;
  logic              done;

  modport master (
    output we, re, a, be, wd, vga_addr, cmd_valid, cmd_op, cmd_fill,
    input  rd, vga_data, cmd_ready, busy, done
  );

  modport slave (
    input  we, re, a, be, wd, vga_addr, cmd_valid, cmd_op, cmd_fill,
    output rd, vga_data, cmd_ready, busy, done
  );

endinterface

// File: rtl/vram_dp_ram.sv
// Simple dual-port cell RAM: port A read/write with byte enables, port B
// read-only. Both reads are registered and return the old contents when the
// same cell is written in the same cycle.
module vram_dp_ram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          en_a,
  input  logic [3:0]    we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [31:0]   wd_a,
  output logic [31:0]   q_a,
  input  logic [AW-1:0] addr_b,
  output logic [31:0]   q_b
);

  logic [31:0] mem [DEPTH];

  // Port A: byte-masked write and registered read of the pre-write contents.
  always_ff @(posedge clk) begin
    if (en_a) begin
      for (int i = 0; i < 4; i++) begin
        if (we_a[i]) mem[addr_a][i*8 +: 8] <= wd_a[i*8 +: 8];
      end
      q_a <= mem[addr_a];
    end
  end

  // Port B: free-running registered display read.
  always_ff @(posedge clk) begin
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/vram_text_engine.sv
// Text-mode VRAM with CPU port, VGA read port and a CLEAR / SCROLL-UP engine.
// The CPU always wins the shared port; the engine simply waits a cycle.
module vram_text_engine
  import vram_text_engine_pkg::*;
#(
  parameter int COLS   = VRAM_COLS,
  parameter int ROWS   = VRAM_ROWS,
  parameter int ADDR_W = 14
) (
  input logic               clk,
  input logic               reset,
  vram_text_engine_if.slave bus
);

  localparam int CELLS     = COLS * ROWS;
  localparam int IDX_W     = $clog2(CELLS);
  localparam int LAST      = CELLS - 1;
  localparam int MOVE_LAST = (ROWS > 1) ? CELLS - COLS - 1 : 0;
  localparam bit HAS_MOVE  = (ROWS > 1);

  logic [ADDR_W-3:0] cpu_cell;
  logic [IDX_W-1:0]  cpu_idx;
  logic              cpu_ok;
  logic              cpu_act;
  logic              vga_in_range;
  logic              unused_addr_bits;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [31:0]       ram_wd;
  logic [31:0]       ram_q;
  logic [IDX_W-1:0]  vga_idx;
  logic [31:0]       vga_q;

  vram_state_t       state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic              stall, start;
  logic              eng_en, eng_we, eng_rd;
  logic [IDX_W-1:0]  eng_addr;
  logic [31:0]       eng_wd;

  vram_op_t          op;
  logic [31:0]       fill;
  logic [31:0]       hold;
  logic              rd_pending;
  logic              rd_from_ram;
  logic [31:0]       rd_hold;
  logic              vga_ok;

  assign cpu_cell         = bus.a[ADDR_W-1:2];
  assign cpu_ok           = cpu_cell < (ADDR_W-2)'(CELLS);
  assign cpu_idx          = cpu_ok ? cpu_cell[IDX_W-1:0] : '0;
  assign cpu_act          = bus.we | bus.re;
  assign unused_addr_bits = ^bus.a[1:0];
  assign vga_in_range     = {1'b0, bus.vga_addr} < (IDX_W+1)'(CELLS);
  assign vga_idx          = vga_in_range ? bus.vga_addr : '0;

  // Port A arbitration: any CPU access takes the port, otherwise the engine.
  always_comb begin
    ram_en   = eng_en;
    ram_we   = {4{eng_we}};
    ram_addr = eng_addr;
    ram_wd   = eng_wd;
    if (cpu_act) begin
      ram_en   = 1'b1;
      ram_we   = (bus.we && cpu_ok) ? bus.be : 4'b0000;
      ram_addr = cpu_idx;
      ram_wd   = bus.wd;
    end
  end

  vram_dp_ram #(.DEPTH(CELLS), .AW(IDX_W)) u_ram (
    .clk    (clk),
    .en_a   (ram_en),
    .we_a   (ram_we),
    .addr_a (ram_addr),
    .wd_a   (ram_wd),
    .q_a    (ram_q),
    .addr_b (vga_idx),
    .q_b    (vga_q)
  );

  // Engine next-state and port requests; a stalled cycle leaves everything as is.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    start    = 1'b0;
    eng_en   = 1'b0;
    eng_we   = 1'b0;
    eng_rd   = 1'b0;
    eng_addr = idx;
    eng_wd   = fill;
    stall    = cpu_act | reset;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nx = ST_IDLE;
        if (bus.cmd_valid) begin
          start  = 1'b1;
          idx_nx = '0;
          if (bus.cmd_op == VRAM_CLEAR) state_nx = ST_CLR_WR;
          else                          state_nx = HAS_MOVE ? ST_SCR_RD : ST_SCR_FILL;
        end
      end
      ST_CLR_WR, ST_SCR_FILL: begin
        if (!stall) begin
          eng_en = 1'b1;
          eng_we = 1'b1;
          idx_nx = idx + 1'b1;
          if (idx == IDX_W'(LAST)) state_nx = ST_DONE;
        end
      end
      ST_SCR_RD: begin
        if (!stall) begin
          eng_en   = 1'b1;
          eng_rd   = 1'b1;
          eng_addr = idx + IDX_W'(COLS);
          state_nx = ST_SCR_WR;
        end
      end
      ST_SCR_WR: begin
        if (!stall) begin
          eng_en   = 1'b1;
          eng_we   = 1'b1;
          eng_wd   = rd_pending ? ram_q : hold;
          idx_nx   = idx + 1'b1;
          state_nx = (idx == IDX_W'(MOVE_LAST)) ? ST_SCR_FILL : ST_SCR_RD;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control registers: FSM, cell counter and read-path select flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      rd_pending  <= 1'b0;
      rd_from_ram <= 1'b0;
      rd_hold     <= '0;
      vga_ok      <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      rd_pending  <= eng_rd;
      rd_from_ram <= bus.re & cpu_ok;
      vga_ok      <= vga_in_range;
      if (rd_from_ram)         rd_hold <= ram_q;
      if (bus.re && !cpu_ok)   rd_hold <= '0;
    end
  end

  // Command latch and scroll hold register; the hold captures the source cell
  // on the cycle after the engine read so a stalling CPU access cannot alter it.
  always_ff @(posedge clk) begin
    if (start) begin
      op   <= bus.cmd_op;
      fill <= bus.cmd_fill;
    end
    if (rd_pending) hold <= ram_q;
  end

  logic unused_op;
  assign unused_op = op;

  assign bus.rd        = rd_from_ram ? ram_q : rd_hold;
  assign bus.vga_data  = vga_ok ? vga_q : 32'h0;
  assign bus.busy      = is_busy(state);
  assign bus.cmd_ready = ~is_busy(state);
  assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_vram_text_engine.sv
// Directed self-checking bench for vram_text_engine: CPU/VGA vector table,
// then CLEAR, SCROLL, stalled SCROLL and reset-abort sequences.
module tb_vram_text_engine;
  import vram_text_engine_pkg::*;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [10:0] vga_addr;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          chk_vga;
    logic [31:0] exp_vga;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[$];

  vram_text_engine_if bus ();

  vram_text_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Watchdog so a wedged design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.we        = 1'b0;
    bus.re        = 1'b0;
    bus.a         = '0;
    bus.be        = 4'h0;
    bus.wd        = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = VRAM_CLEAR;
    bus.cmd_fill  = '0;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.we       = v.we;
    bus.re       = v.re;
    bus.a        = v.a;
    bus.be       = v.be;
    bus.wd       = v.wd;
    bus.vga_addr = v.vga_addr;
    tick();
    set_idle();
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic re,
                              input logic [13:0] a, input logic [3:0] be, input logic [31:0] wd,
                              input logic [10:0] vga_addr, input bit chk_rd, input logic [31:0] exp_rd,
                              input bit chk_vga, input logic [31:0] exp_vga);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.a = a; v.be = be; v.wd = wd;
    v.vga_addr = vga_addr; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.chk_vga = chk_vga; v.exp_vga = exp_vga;
    return v;
  endfunction

  // Expected screen image for each phase of the test.
  function automatic logic [31:0] exp_cell(input int kind, input int i);
    logic [31:0] scr2;
    scr2 = (i == 0) ? 32'hCAFEF00D :
           (i < CELLS - COLS) ? 32'h1000_0000 + 32'(i + COLS) : 32'h0000_0720;
    case (kind)
      0: return 32'h0000_0020;
      1: return (i < CELLS - COLS) ? 32'(i + COLS) : 32'h0;
      2: return scr2;
      default: return (i < 99) ? 32'h5555_5555 : scr2;
    endcase
  endfunction

  function automatic int stalled_scroll_done();
    int work;
    work = 2 * (CELLS - COLS) + COLS;
    for (int n = 1; n < 100000; n++) begin
      if (!((n == 2) || (n % 3 == 0))) work--;
      if (work == 0) return n + 1;
    end
    return -1;
  endfunction

  task automatic preload(input logic [31:0] base);
    for (int i = 0; i < CELLS; i++) begin
      bus.we = 1'b1;
      bus.be = 4'hF;
      bus.a  = 14'(i * 4);
      bus.wd = base + 32'(i);
      tick();
    end
    set_idle();
  endtask

  task automatic read_all(input int kind, input string name);
    int bad_rd = 0;
    int bad_vga = 0;
    for (int i = 0; i < CELLS; i++) begin
      bus.re       = 1'b1;
      bus.a        = 14'(i * 4);
      bus.vga_addr = 11'(i);
      tick();
      if (bus.rd !== exp_cell(kind, i)) begin
        if (bad_rd == 0) $display("[TB] first bad cell %0d rd=%h want %h", i, bus.rd, exp_cell(kind, i));
        bad_rd++;
      end
      if (bus.vga_data !== exp_cell(kind, i)) bad_vga++;
    end
    set_idle();
    check_output({name, "_rd_bad_cells"}, 32'(bad_rd), 32'h0);
    check_output({name, "_vga_bad_cells"}, 32'(bad_vga), 32'h0);
  endtask

  // Issue one command and follow it to completion; the stalled variant also
  // writes the scroll source cell on the accept cycle and while a read is held,
  // fires an ignored second command and reads every third cycle.
  task automatic run_cmd(input vram_op_t op, input logic [31:0] fill, input bit stalls,
                         input int exp_done, input string name);
    int done_at = -1;
    int pulses = 0;
    int busy_bad = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_fill  = fill;
    if (stalls) begin
      bus.we = 1'b1; bus.a = 14'(COLS * 4); bus.be = 4'hF; bus.wd = 32'hCAFEF00D;
    end
    tick();
    set_idle();
    for (int n = 1; n <= exp_done + 20; n++) begin
      if (stalls) begin
        if (n == 1) begin
          bus.cmd_valid = 1'b1; bus.cmd_op = VRAM_CLEAR; bus.cmd_fill = 32'hFFFF_FFFF;
        end
        if (n == 2) begin
          bus.we = 1'b1; bus.a = 14'(COLS * 4); bus.be = 4'hF; bus.wd = 32'hBAD0BAD0;
        end
        if (n % 3 == 0) begin
          bus.re = 1'b1; bus.a = 14'h0004;
        end
      end
      if (bus.done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = n;
      end
      if (bus.busy !== (n < exp_done)) busy_bad++;
      if (done_at >= 0 && n >= done_at + 2) break;
      tick();
      set_idle();
    end
    set_idle();
    check_output({name, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check_output({name, "_done_pulses"}, 32'(pulses), 32'd1);
    check_output({name, "_busy_bad_cycles"}, 32'(busy_bad), 32'd0);
    check_output({name, "_cmd_ready_after"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  // Main sequence.
  initial begin
    set_idle();
    bus.vga_addr = '0;
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;

    check_output("reset_rd", bus.rd, 32'h0);
    check_output("reset_vga", bus.vga_data, 32'h0);
    check_output("reset_busy", 32'(bus.busy), 32'h0);
    check_output("reset_done", 32'(bus.done), 32'h0);
    check_output("reset_cmd_ready", 32'(bus.cmd_ready), 32'h1);

    vecs.push_back(mk("wr_c1",     1, 0, 14'h0004, 4'hF, 32'h00FF0041, 11'd1,    1, 32'h0,        0, 32'h0));
    vecs.push_back(mk("rd_c1",     0, 1, 14'h0004, 4'h0, 32'h0,        11'd1,    1, 32'h00FF0041, 1, 32'h00FF0041));
    vecs.push_back(mk("be0_c1",    1, 0, 14'h0004, 4'h1, 32'hFFFFFF42, 11'd1,    1, 32'h00FF0041, 1, 32'h00FF0041));
    vecs.push_back(mk("rd_c1_be",  0, 1, 14'h0004, 4'h0, 32'h0,        11'd1,    1, 32'h00FF0042, 1, 32'h00FF0042));
    vecs.push_back(mk("wr_c2",     1, 0, 14'h0008, 4'hF, 32'h11223344, 11'd2,    1, 32'h00FF0042, 0, 32'h0));
    vecs.push_back(mk("be_mix_c2", 1, 0, 14'h0008, 4'hA, 32'hAABBCCDD, 11'd2,    1, 32'h00FF0042, 1, 32'h11223344));
    vecs.push_back(mk("rd_c2_a11", 0, 1, 14'h000B, 4'h0, 32'h0,        11'd2,    1, 32'hAA22CC44, 1, 32'hAA22CC44));
    vecs.push_back(mk("wr_c0",     1, 0, 14'h0000, 4'hF, 32'h0,        11'd0,    1, 32'hAA22CC44, 0, 32'h0));
    vecs.push_back(mk("wr_oob",    1, 0, 14'h12C0, 4'hF, 32'hDEADBEEF, 11'd1200, 1, 32'hAA22CC44, 1, 32'h0));
    vecs.push_back(mk("rd_oob",    0, 1, 14'h12C0, 4'h0, 32'h0,        11'd2047, 1, 32'h0,        1, 32'h0));
    vecs.push_back(mk("rd_c0",     0, 1, 14'h0000, 4'h0, 32'h0,        11'd0,    1, 32'h0,        1, 32'h0));
    vecs.push_back(mk("wr_last",   1, 0, 14'h12BC, 4'hF, 32'h12345678, 11'd1199, 1, 32'h0,        0, 32'h0));
    vecs.push_back(mk("rd_last",   0, 1, 14'h12BC, 4'h0, 32'h0,        11'd1199, 1, 32'h12345678, 1, 32'h12345678));

    foreach (vecs[k]) begin
      apply_stimulus(vecs[k]);
      if (vecs[k].chk_rd)  check_output({vecs[k].name, "_rd"},  bus.rd,       vecs[k].exp_rd);
      if (vecs[k].chk_vga) check_output({vecs[k].name, "_vga"}, bus.vga_data, vecs[k].exp_vga);
    end

    // CLEAR the whole screen.
    run_cmd(VRAM_CLEAR, 32'h0000_0020, 1'b0, CELLS + 1, "clear");
    read_all(0, "clear");

    // SCROLL a numbered screen up by one row.
    preload(32'h0);
    run_cmd(VRAM_SCROLL, 32'h0, 1'b0, 2 * (CELLS - COLS) + COLS + 1, "scroll");
    read_all(1, "scroll");

    // SCROLL again with CPU contention and an ignored second command.
    preload(32'h1000_0000);
    run_cmd(VRAM_SCROLL, 32'h0000_0720, 1'b1, stalled_scroll_done(), "scroll_stall");
    read_all(2, "scroll_stall");

    // Abort a CLEAR with reset after 99 cells.
    bus.cmd_valid = 1'b1; bus.cmd_op = VRAM_CLEAR; bus.cmd_fill = 32'h5555_5555;
    tick();
    set_idle();
    for (int n = 1; n < 100; n++) tick();
    reset = 1'b1;
    tick();
    check_output("abort_busy", 32'(bus.busy), 32'h0);
    check_output("abort_done", 32'(bus.done), 32'h0);
    check_output("abort_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check_output("abort_rd", bus.rd, 32'h0);
    reset = 1'b0;
    tick(); tick();
    check_output("abort_still_idle", 32'(bus.busy), 32'h0);
    read_all(3, "abort");

    // Out-of-range write is dropped and its read returns zero.
    bus.we = 1'b1; bus.a = 14'(CELLS * 4); bus.be = 4'hF; bus.wd = 32'h0BAD_CAFE;
    tick();
    set_idle();
    bus.re = 1'b1; bus.a = 14'(CELLS * 4);
    tick();
    set_idle();
    check_output("final_oob_rd", bus.rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
